// File: rtl/fir_serial_mac_pkg.sv
// Shared constants for the sample-path FIR blocks: state encoding, default widths,
// and a clog2 helper for tools that do not fold $clog2 in every parameter context.
package fir_pkg;

  localparam int DATA_W_DEF = 18;
  localparam int COEF_W_DEF = 16;
  localparam int FRAC_W_DEF = 15;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_MAC  = 2'd1;
  localparam logic [1:0] ST_OUT  = 2'd2;

  function automatic int clog2(input int n);
    int r;
    r = 0;
    while ((1 << r) < n) r++;
    return r;
  endfunction

endpackage

// File: rtl/fir_serial_mac_if.sv
// Sample handshake, coefficient write port and filtered-output strobe of the serial FIR.
interface fir_serial_mac_if
  import fir_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int COEF_W = COEF_W_DEF,
  parameter int TAPS   = 11
) ();

  localparam int ADDR_W = clog2(TAPS);

  logic                     i_valid;
  logic                     o_ready;
  logic signed [DATA_W-1:0] i_data;
  logic                     i_coef_we;
  logic [ADDR_W-1:0]        i_coef_addr;
  logic signed [COEF_W-1:0] i_coef_data;
  logic                     o_valid;
  logic signed [DATA_W-1:0] o_data;
  logic                     o_sat;

  modport master (
    output i_valid, i_data, i_coef_we, i_coef_addr, i_coef_data,
    input  o_ready, o_valid, o_data, o_sat
  );

  modport slave (
    input  i_valid, i_data, i_coef_we, i_coef_addr, i_coef_data,
    output o_ready, o_valid, o_data, o_sat
  );

endinterface

// File: rtl/fir_round_sat.sv
// Accumulator to sample conversion: drop FRAC_W bits with round-half-to-even,
// then clip to the signed DATA_W range and flag the clip.
module fir_round_sat #(
  parameter int ACC_W  = 38,
  parameter int FRAC_W = 15,
  parameter int DATA_W = 18
) (
  input  logic signed [ACC_W-1:0]  i_acc,
  output logic signed [DATA_W-1:0] o_data,
  output logic                     o_sat
);

  // One spare bit so the round-up increment can never wrap.
  localparam int Q_W = ACC_W - FRAC_W + 1;
  localparam logic signed [Q_W-1:0] MAX_Q = Q_W'((64'sd1 <<< (DATA_W - 1)) - 64'sd1);
  localparam logic signed [Q_W-1:0] MIN_Q = Q_W'(-(64'sd1 <<< (DATA_W - 1)));

  logic signed [Q_W-1:0] q;
  logic signed [Q_W-1:0] r;
  logic                  g;
  logic                  s;
  logic                  inc;

  assign q   = Q_W'(i_acc >>> FRAC_W);
  assign g   = i_acc[FRAC_W-1];
  assign s   = |i_acc[FRAC_W-2:0];
  assign inc = g && (s || q[0]);
  assign r   = q + {{(Q_W-1){1'b0}}, inc};

  always_comb begin
    o_data = r[DATA_W-1:0];
    o_sat  = 1'b0;
    if (r > MAX_Q) begin
      o_data = MAX_Q[DATA_W-1:0];
      o_sat  = 1'b1;
    end else if (r < MIN_Q) begin
      o_data = MIN_Q[DATA_W-1:0];
      o_sat  = 1'b1;
    end
  end

endmodule

// File: rtl/fir_serial_mac.sv
// Time-multiplexed FIR: one shared multiplier walks the taps once per accepted sample.
//   state   | meaning
//   IDLE    | o_ready high, waiting for a sample; coefficient writes accepted
//   MAC     | one delay*coef product accumulated per cycle, tap 0 .. TAPS-1
//   OUT     | rounded/saturated result registered, o_valid strobed
module fir_serial_mac
  import fir_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int COEF_W = COEF_W_DEF,
  parameter int TAPS   = 11,
  parameter int FRAC_W = FRAC_W_DEF
) (
  input  logic             i_clk,
  input  logic             i_rst,
  fir_serial_mac_if.slave  bus
);

  localparam int ADDR_W = clog2(TAPS);
  localparam int PROD_W = DATA_W + COEF_W;
  localparam int ACC_W  = DATA_W + COEF_W + clog2(TAPS);
  localparam logic [ADDR_W-1:0] LAST_TAP = ADDR_W'(TAPS - 1);
  localparam logic [ADDR_W:0]   TAPS_L   = (ADDR_W + 1)'(TAPS);

  logic [1:0]               state;
  logic signed [DATA_W-1:0] delay [TAPS];
  logic signed [COEF_W-1:0] coef  [TAPS];
  logic [ADDR_W-1:0]        cnt;
  logic signed [ACC_W-1:0]  acc;
  logic signed [PROD_W-1:0] prod;
  logic signed [DATA_W-1:0] rs_data;
  logic                     rs_sat;
  logic                     accept;
  logic                     coef_wr;

  assign bus.o_ready = (state == ST_IDLE);
  assign accept      = bus.i_valid && bus.o_ready;
  assign coef_wr     = bus.i_coef_we && (state == ST_IDLE) && ({1'b0, bus.i_coef_addr} < TAPS_L);
  assign prod        = delay[cnt] * coef[cnt];

  fir_round_sat #(
    .ACC_W  (ACC_W),
    .FRAC_W (FRAC_W),
    .DATA_W (DATA_W)
  ) u_round_sat (
    .i_acc  (acc),
    .o_data (rs_data),
    .o_sat  (rs_sat)
  );

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state       <= ST_IDLE;
      cnt         <= '0;
      acc         <= '0;
      bus.o_valid <= 1'b0;
      bus.o_data  <= '0;
      bus.o_sat   <= 1'b0;
      for (int k = 0; k < TAPS; k++) begin
        delay[k] <= '0;
        coef[k]  <= '0;
      end
    end else begin
      bus.o_valid <= 1'b0;
      // A write in the accepting cycle lands before the first MAC read.
      if (coef_wr) coef[bus.i_coef_addr] <= bus.i_coef_data;
      case (state)
        ST_IDLE: begin
          if (accept) begin
            delay[0] <= bus.i_data;
            for (int k = 1; k < TAPS; k++) delay[k] <= delay[k-1];
            acc   <= '0;
            cnt   <= '0;
            state <= ST_MAC;
          end
        end
        ST_MAC: begin
          acc <= acc + ACC_W'(prod);
          if (cnt == LAST_TAP) state <= ST_OUT;
          else                 cnt   <= cnt + ADDR_W'(1);
        end
        ST_OUT: begin
          bus.o_data  <= rs_data;
          bus.o_sat   <= rs_sat;
          bus.o_valid <= 1'b1;
          state       <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_fir_serial_mac.sv
// Bench for fir_serial_mac: directed plan items plus random samples/writes against an arithmetic model.
module tb_fir_serial_mac;
  import fir_pkg::*;

  localparam int DW = 18;
  localparam int CW = 16;
  localparam int NT = 11;
  localparam int FW = 15;
  localparam int AW = clog2(NT);

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  fir_serial_mac_if #(.DATA_W(DW), .COEF_W(CW), .TAPS(NT)) bus ();

  fir_serial_mac #(.DATA_W(DW), .COEF_W(CW), .TAPS(NT), .FRAC_W(FW)) dut (
    .i_clk (clk),
    .i_rst (rst),
    .bus   (bus.slave)
  );

  int     vectors     = 0;
  int     miscompares = 0;
  longint coef_m [NT];
  longint hist_m [NT];
  longint last_data;
  longint last_sat;

  task automatic chk(input string tag, input longint got, input longint exp);
    vectors++;
    if (got != exp) begin
      miscompares++;
      $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
    end
  endtask

  // Exact sum of products, floor-divide by 2^FW, ties to even, clip.
  function automatic longint model_out(output longint sat);
    longint acc, q, rem, half, maxv, minv;
    acc = 0;
    for (int k = 0; k < NT; k++) acc += hist_m[k] * coef_m[k];
    q    = acc >>> FW;
    rem  = acc - q * (longint'(1) <<< FW);
    half = longint'(1) <<< (FW - 1);
    if (rem > half) q++;
    else if (rem == half && (q % 2 != 0)) q++;
    maxv = (longint'(1) <<< (DW - 1)) - 1;
    minv = -(longint'(1) <<< (DW - 1));
    sat = 0;
    if (q > maxv) begin q = maxv; sat = 1; end
    else if (q < minv) begin q = minv; sat = 1; end
    return q;
  endfunction

  task automatic do_reset();
    rst             = 1'b1;
    bus.i_valid     = 1'b0;
    bus.i_data      = '0;
    bus.i_coef_we   = 1'b0;
    bus.i_coef_addr = '0;
    bus.i_coef_data = '0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    for (int k = 0; k < NT; k++) begin coef_m[k] = 0; hist_m[k] = 0; end
  endtask

  task automatic write_coef(input int addr, input longint val);
    bus.i_coef_we   = 1'b1;
    bus.i_coef_addr = AW'(addr);
    bus.i_coef_data = CW'(val);
    @(posedge clk); #1;
    bus.i_coef_we = 1'b0;
    if (addr < NT) coef_m[addr] = val;
  endtask

  // Called 1 time unit after an edge with the DUT in IDLE; returns after the o_valid sample.
  task automatic send_sample(input longint d, input bit wr_now, input int waddr, input longint wdata,
                             input bit wr_mac, input bit junk);
    int     cyc;
    bit     seen;
    longint exp_d, exp_s;
    bus.i_valid = 1'b1;
    bus.i_data  = DW'(d);
    if (wr_now) begin
      bus.i_coef_we   = 1'b1;
      bus.i_coef_addr = AW'(waddr);
      bus.i_coef_data = CW'(wdata);
    end
    @(posedge clk); #1;
    bus.i_valid   = junk;
    bus.i_data    = junk ? DW'($urandom) : '0;
    bus.i_coef_we = 1'b0;
    if (wr_now && waddr < NT) coef_m[waddr] = wdata;
    for (int k = NT - 1; k > 0; k--) hist_m[k] = hist_m[k-1];
    hist_m[0] = d;
    exp_d = model_out(exp_s);
    chk("strobe_len", longint'(bus.o_valid), 0);
    cyc  = 0;
    seen = 1'b0;
    while (!seen && cyc < 20) begin
      if (wr_mac && cyc == 3) begin
        bus.i_coef_we   = 1'b1;
        bus.i_coef_addr = '0;
        bus.i_coef_data = 16'sh7FFF;
      end else begin
        bus.i_coef_we = 1'b0;
      end
      @(posedge clk); #1;
      cyc++;
      seen = bus.o_valid;
    end
    bus.i_valid   = 1'b0;
    bus.i_coef_we = 1'b0;
    chk("latency", cyc, NT + 1);
    chk("ready_in_valid", longint'(bus.o_ready), 1);
    last_data = longint'($signed(bus.o_data));
    last_sat  = longint'(bus.o_sat);
    chk("data", last_data, exp_d);
    chk("sat", last_sat, exp_s);
  endtask

  initial begin
    int seen_v;
    int rin [5];
    int rout[5];
    rin  = '{16384, 49152, -16384, -49152, 16385};
    rout = '{0, 2, 0, -2, 1};

    do_reset();
    chk("rst_ready", longint'(bus.o_ready), 1);
    chk("rst_valid", longint'(bus.o_valid), 0);
    chk("rst_data", longint'($signed(bus.o_data)), 0);
    chk("rst_sat", longint'(bus.o_sat), 0);

    write_coef(0, 16'h4000);
    send_sample(1000, 0, 0, 0, 0, 0);
    chk("gain_data", last_data, 500);
    chk("gain_sat", last_sat, 0);

    do_reset();
    for (int k = 0; k < NT; k++) write_coef(k, 100 * (k + 1));
    for (int i = 0; i < NT; i++) begin
      send_sample(i == 0 ? 32768 : 0, 0, 0, 0, 0, 1);
      chk($sformatf("impulse_%0d", i), last_data, 100 * (i + 1));
    end

    do_reset();
    write_coef(0, 1);
    for (int i = 0; i < 5; i++) begin
      send_sample(rin[i], 0, 0, 0, 0, 0);
      chk($sformatf("round_%0d", i), last_data, rout[i]);
    end

    do_reset();
    for (int k = 0; k < NT; k++) write_coef(k, 16'h7FFF);
    for (int i = 0; i < NT; i++) send_sample(131071, 0, 0, 0, 0, 0);
    chk("sat_pos_data", last_data, 131071);
    chk("sat_pos_flag", last_sat, 1);
    for (int i = 0; i < NT; i++) send_sample(-131072, 0, 0, 0, 0, 0);
    chk("sat_neg_data", last_data, -131072);
    chk("sat_neg_flag", last_sat, 1);

    do_reset();
    write_coef(0, 16'h4000);
    send_sample(1000, 0, 0, 0, 1, 0);
    send_sample(2000, 0, 0, 0, 0, 0);
    chk("mac_write_dropped", last_data, 1000);
    write_coef(11, 16'h7FFF);
    send_sample(-4000, 0, 0, 0, 0, 0);
    chk("oob_write_dropped", last_data, -2000);
    send_sample(600, 1, 0, 16'h2000, 0, 0);
    chk("same_cycle_write", last_data, 150);

    // Abort mid-MAC: reset sampled on the fifth MAC edge.
    for (int k = 0; k < NT; k++) write_coef(k, 16'h1234);
    bus.i_valid = 1'b1;
    bus.i_data  = 18'sd5000;
    @(posedge clk); #1;
    bus.i_valid = 1'b0;
    repeat (4) @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    chk("abort_ready", longint'(bus.o_ready), 1);
    for (int k = 0; k < NT; k++) begin coef_m[k] = 0; hist_m[k] = 0; end
    seen_v = 0;
    for (int i = 0; i < 15; i++) begin
      @(posedge clk); #1;
      if (bus.o_valid) seen_v++;
    end
    chk("abort_no_valid", seen_v, 0);
    send_sample(70000, 0, 0, 0, 0, 0);
    chk("abort_cleared", last_data, 0);

    for (int i = 0; i < 60; i++) begin
      int     nw;
      longint d;
      nw = $urandom_range(0, 2);
      for (int w = 0; w < nw; w++)
        write_coef($urandom_range(0, 15), longint'($urandom_range(0, 65535)) - 32768);
      d = longint'($urandom_range(0, 262143)) - 131072;
      send_sample(d, $urandom_range(0, 1), $urandom_range(0, 15),
                  longint'($urandom_range(0, 65535)) - 32768,
                  $urandom_range(0, 1), $urandom_range(0, 1));
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
